// File: rtl/flptadder_normalize_pack.sv
// Normalization and packing stage of the 10-bit float adder.
// Takes the sign-magnitude mantissa sum and the aligned exponent, walks the
// leading one into the hidden-bit position one bit per cycle, then packs
// {sign, exp[4:0], frac[3:0]} with saturation on overflow and flush on underflow.
module flptadder_normalize_pack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] signed_mantissa_sum,
  input  logic [4:0] exp_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] result,
  output logic       out_ovf,
  output logic       out_unf
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic        sign_r, sign_nxt;
  logic [5:0]  mag_r, mag_nxt;
  logic [4:0]  exp_r, exp_nxt;
  logic [9:0]  result_nxt;
  logic        ovf_nxt, unf_nxt;

  // Truncating pack: a carry drops the mantissa LSB and bumps the exponent,
  // otherwise bits [3:0] below the hidden one become the fraction.
  function automatic logic [9:0] pack_trunc(input logic       s,
                                            input logic [4:0] e,
                                            input logic [5:0] m,
                                            input logic       carry);
    logic [4:0] e_inc;
    e_inc = e + 5'd1;
    if (carry) return {s, e_inc, m[4:1]};
    else       return {s, e, m[3:0]};
  endfunction

  // Largest representable magnitude with the operand sign kept.
  function automatic logic [9:0] saturate(input logic s);
    return {s, 5'h1F, 4'hF};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next-state, datapath and packing decisions for the current state.
  always_comb begin
    state_nxt  = state;
    sign_nxt   = sign_r;
    mag_nxt    = mag_r;
    exp_nxt    = exp_r;
    result_nxt = result;
    ovf_nxt    = out_ovf;
    unf_nxt    = out_unf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nxt  = signed_mantissa_sum[6];
          mag_nxt   = signed_mantissa_sum[5:0];
          exp_nxt   = exp_in;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (mag_r == 6'd0 || exp_r == 5'd0) begin
          // Zero operand or zero sum: positive zero, no flags.
          result_nxt = 10'h000;
          ovf_nxt    = 1'b0;
          unf_nxt    = 1'b0;
          state_nxt  = DONE;
        end else if (mag_r[5] && exp_r == 5'h1F) begin
          result_nxt = saturate(sign_r);
          ovf_nxt    = 1'b1;
          unf_nxt    = 1'b0;
          state_nxt  = DONE;
        end else if (mag_r[5] || mag_r[4]) begin
          result_nxt = pack_trunc(sign_r, exp_r, mag_r, mag_r[5]);
          ovf_nxt    = 1'b0;
          unf_nxt    = 1'b0;
          state_nxt  = DONE;
        end else if (exp_r == 5'd1) begin
          // Another left shift would need exponent 0: flush to zero.
          result_nxt = 10'h000;
          ovf_nxt    = 1'b0;
          unf_nxt    = 1'b1;
          state_nxt  = DONE;
        end else begin
          mag_nxt = {mag_r[4:0], 1'b0};
          exp_nxt = exp_r - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working mantissa/exponent and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      mag_r   <= 6'd0;
      exp_r   <= 5'd0;
      result  <= 10'h000;
      out_ovf <= 1'b0;
      out_unf <= 1'b0;
    end else begin
      state   <= state_nxt;
      sign_r  <= sign_nxt;
      mag_r   <= mag_nxt;
      exp_r   <= exp_nxt;
      result  <= result_nxt;
      out_ovf <= ovf_nxt;
      out_unf <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_flptadder_normalize_pack.sv
// Scoreboard bench for flptadder_normalize_pack: a driver pushes expected
// packed results from a value-level model, a monitor pops and compares.
module tb_flptadder_normalize_pack;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] signed_mantissa_sum;
  logic [4:0] exp_in;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] result;
  logic       out_ovf;
  logic       out_unf;

  flptadder_normalize_pack dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .signed_mantissa_sum (signed_mantissa_sum),
    .exp_in              (exp_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .result              (result),
    .out_ovf             (out_ovf),
    .out_unf             (out_unf)
  );

  typedef struct {
    logic [9:0] res;
    logic       ovf;
    logic       unf;
    int         lat;
    int         e0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic busy = 1'b0;
  int   or_mode = 1;   // 0 random, 1 hold low, 2 hold high

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Value-level reference: find the leading one, count shifts needed to
  // bring it to bit 4, and decide saturation / flush from the exponent.
  function automatic exp_t model(input logic [6:0] s, input logic [4:0] e);
    exp_t r;
    int mag, ex, p, k;
    mag = int'(s[5:0]);
    ex  = int'(e);
    r.res = 10'h000; r.ovf = 1'b0; r.unf = 1'b0; r.lat = 1; r.e0 = 0;
    if (mag == 0 || ex == 0) return r;
    p = $clog2(mag + 1) - 1;
    if (p == 5) begin
      if (ex == 31) begin
        r.res = {s[6], 9'h1FF};
        r.ovf = 1'b1;
      end else begin
        r.res = {s[6], 5'(ex + 1), 4'((mag >> 1) & 15)};
      end
    end else begin
      k = 4 - p;
      if (ex <= k) begin
        r.unf = 1'b1;
        r.lat = ex;
      end else begin
        r.lat = k + 1;
        r.res = {s[6], 5'(ex - k), 4'((mag << k) & 15)};
      end
    end
    return r;
  endfunction

  task automatic send(input logic [6:0] s, input logic [4:0] e);
    int guard;
    exp_t r;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    signed_mantissa_sum = s;
    exp_in   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    r = model(s, e);
    r.e0 = cyc;
    sb.push_back(r);
    busy = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares presented results against the scoreboard head.
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        chk("in_ready", int'(in_ready), int'(!busy));
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            if (!prev_ov) chk("latency", cyc - sb[0].e0, sb[0].lat);
            chk("result", int'(result), int'(sb[0].res));
            chk("out_ovf", int'(out_ovf), int'(sb[0].ovf));
            chk("out_unf", int'(out_unf), int'(sb[0].unf));
            if (out_ready) begin
              void'(sb.pop_front());
              busy = 1'b0;
            end
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    int guard;
    logic [6:0] s;
    logic [4:0] e;
    rst_n = 1'b0;
    in_valid = 1'b0;
    signed_mantissa_sum = 7'd0;
    exp_in = 5'd0;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_ovf", int'(out_ovf), 0);
    chk("rst_unf", int'(out_unf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases with a free-running downstream
    or_mode = 2;
    send(7'b0_100110, 5'd16);   // carry -> 0x113
    send(7'b1_011010, 5'd10);   // already normal -> 0x2AA
    send(7'b0_000011, 5'd20);   // three shifts -> 0x118
    send(7'b1_000000, 5'd9);    // zero sum, sign cleared
    send(7'b0_110000, 5'd31);   // overflow -> 0x1FF
    send(7'b1_000001, 5'd2);    // underflow after one shift
    send(7'b1_010101, 5'd0);    // zero exponent operand
    send(7'b0_000001, 5'd5);    // four shifts, still representable
    send(7'b1_111111, 5'd30);   // carry into exponent 31
    drain();

    // Backpressure: DONE held, inputs ignored, then one accept cycle
    or_mode = 1;
    @(posedge clk);
    #3;
    send(7'b1_011010, 5'd10);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) chk("bp_wait_timeout", 0, 1);
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b1;
      signed_mantissa_sum = 7'($urandom);
      exp_in = 5'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_hold_valid", int'(out_valid), 1);
    end
    or_mode = 2;
    @(posedge clk);
    #3;
    or_mode = 1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_result_held", int'(result), 10'h2AA);

    // Reset in the middle of normalization
    send(7'b0_000011, 5'd20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_ovf", int'(out_ovf), 0);
    chk("midrst_unf", int'(out_unf), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    busy = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    or_mode = 0;
    send(7'b0_000011, 5'd20);
    drain();

    // Randomized beats under random backpressure
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       e = 5'd0;
        1:       e = 5'd1;
        2:       e = 5'd31;
        3:       e = 5'($urandom_range(2, 4));
        default: e = 5'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) s = {1'($urandom), 6'($urandom_range(0, 7))};
      else                           s = 7'($urandom);
      send(s, e);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flptadder_normalize_pack.md
# flptadder_normalize_pack

Post-addition normalization and packing stage of the 10-bit floating-point adder in the FIR datapath. Consumes the 7-bit sign-magnitude mantissa sum produced by the mantissa add/sub stage, plus the aligned (larger) exponent. It normalizes the mantissa iteratively, one bit per cycle, and packs a 10-bit float result {sign, exp[4:0], frac[3:0]}. Overflow saturates and underflow flushes to zero. Valid/ready handshakes are used on both sides.

## Interface
- No parameters. The format is fixed: 1 sign bit, 5-bit exponent (0 encodes zero), 4-bit fraction with hidden 1, truncation rounding.
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept; equals (state == IDLE)
- signed_mantissa_sum  in  7  [6] = sign, [5:0] = magnitude; [5] is the carry/overflow bit and [4] is the hidden-bit position
- exp_in  in  5  exponent of the aligned operands
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts
- result  out  10  packed float {sign, exp, frac}
- out_ovf  out  1  result was saturated; qualified by out_valid
- out_unf  out  1  result was flushed to zero; qualified by out_valid

## Operation
- Reset: asynchronous, active-low. State goes to IDLE. out_valid=0, result=0, out_ovf=0, out_unf=0, and the internal mag/exp/sign registers are cleared. Reset asserted mid-operation abandons the beat.
- The FSM has three states: IDLE, NORM and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture sign, mag[5:0] and exp and go to NORM.
  - If the captured exp_in==0, the beat is treated as a zero operand.
- NORM: evaluates once per cycle, in this priority order:
  - mag==0 or exp==0: result=0x000 with sign forced to 0, no flags, go to DONE.
  - mag[5]==1 and exp==31: result={sign,5'h1F,4'hF}, out_ovf=1, go to DONE.
  - mag[5]==1: frac=mag[4:1] (LSB truncated), exp+1, pack, go to DONE.
  - mag[4]==1: frac=mag[3:0], exp unchanged, pack, go to DONE.
  - Otherwise a left shift is needed:
    - If exp==1: result=0x000, out_unf=1, go to DONE.
    - Else mag<<=1, exp-=1, stay in NORM.
- DONE:
  - out_valid=1. result and flags stay stable.
  - When out_ready is high, go to IDLE.
  - out_valid drops on the next edge; result holds its last value.
- At most 4 left shifts are possible (mag=000001). NORM therefore never exceeds 5 cycles.
- Exponent arithmetic is 5-bit unsigned. Wrap-around cannot occur because of the ovf/unf checks.
- The hidden bit is never stored in result.

## Timing
- Accept edge E0 is the edge where in_valid && in_ready.
- With k left shifts, out_valid rises at edge E0+k+1:
  - Already normal, carry, zero, ovf: out_valid at E0+1.
  - Worst case (mag=1, no underflow): out_valid at E0+5.
- Output handshake completes on the edge where out_valid && out_ready.
  - in_ready goes high on that same edge.
  - A new input is accepted no earlier than the following edge. There is no same-cycle turnaround.
- in_valid while in NORM or DONE is ignored: in_ready=0 and no capture occurs.
- Backpressure: DONE holds indefinitely, with result/flags constant.
- out_ready while out_valid=0 has no effect.
- Throughput is at most one beat per k+2 cycles.

## Test plan
- Carry: sum=7'b0_100110, exp=16.
  - result=0x113 (0_10001_0011), out_valid at E0+1, no flags.
- Already normal: sum=7'b1_011010, exp=10.
  - result=0x2AA (1_01010_1010), out_valid at E0+1.
- Left shift ×3: sum=7'b0_000011, exp=20.
  - result=0x118 (0_10001_1000), out_valid at E0+4, in_ready low for E0..E0+4.
- Zero and exceptions:
  - sum=7'b1_000000, exp=9: result=0x000, sign cleared.
  - sum=7'b0_110000, exp=31: result=0x1FF, out_ovf=1.
  - sum=7'b1_000001, exp=2: result=0x000, out_unf=1, out_valid at E0+2.
- Backpressure:
  - Hold out_ready=0 for 6 cycles after out_valid: result/flags stable, in_ready=0, in_valid pulses ignored.
  - Then out_ready=1 for 1 cycle: out_valid=0 and in_ready=1 on the next edge.
- Reset mid-NORM: drop rst_n during the second shift cycle of the ×3 case.
  - out_valid, result and flags go to 0 immediately, without waiting for a clock.
  - After release, in_ready=1 and a new beat processes correctly.
